// File: rtl/btn_debounce_pkg.sv
// Shared types, default parameters and counter-width helpers for the
// button conditioner bank.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDING = 2'd1,
        HELD    = 2'd2
    } hold_state_t;

    localparam int unsigned DEF_N_CH            = 5;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: input synchroniser, stability-window debouncer and
// long-press hold/auto-repeat state machine.
module btn_debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_held,
    output logic o_repeat
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(max2(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HC_HOLD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HC_REP  = HW'(REPEAT_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_dcnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    hold_state_t            r_state;
    logic [HW-1:0]          r_hcnt;
    logic                   r_held;
    logic                   r_repeat;

    logic                   w_s;
    logic                   w_accept;
    logic                   w_rise;
    logic                   w_fall;

    hold_state_t            w_state_nxt;
    logic [HW-1:0]          w_hcnt_nxt;
    logic                   w_held_nxt;
    logic                   w_repeat_nxt;

    always_comb begin
        w_s      = r_sync[SYNC_STAGES-1];
        w_accept = (w_s != r_level) && (r_dcnt == DC_LAST);
        w_rise   = w_accept && w_s;
        w_fall   = w_accept && !w_s;
    end

    // Any sample matching the current level clears the window, so a bounce
    // restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_press   <= w_rise;
            r_release <= w_fall;
            if (w_s == r_level) begin
                r_dcnt <= '0;
            end else if (w_accept) begin
                r_dcnt  <= '0;
                r_level <= w_s;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_hcnt   <= '0;
            r_held   <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_held   <= w_held_nxt;
            r_repeat <= w_repeat_nxt;
        end
    end

    // A release is acted on in the same cycle the debouncer accepts it, so
    // held drops on the same edge as level.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_held_nxt   = r_held;
        w_repeat_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_hcnt_nxt = '0;
                w_held_nxt = 1'b0;
                if (w_rise) begin
                    w_state_nxt = HOLDING;
                    w_hcnt_nxt  = HW'(1);
                end
            end
            HOLDING: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_hcnt_nxt  = '0;
                    w_held_nxt  = 1'b0;
                end else if (r_hcnt == HC_HOLD) begin
                    w_state_nxt  = HELD;
                    w_held_nxt   = 1'b1;
                    w_repeat_nxt = i_repeat_en;
                    w_hcnt_nxt   = HW'(1);
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_hcnt_nxt  = '0;
                    w_held_nxt  = 1'b0;
                end else if (r_hcnt == HC_REP) begin
                    w_repeat_nxt = i_repeat_en;
                    w_hcnt_nxt   = HW'(1);
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hcnt_nxt  = '0;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_held    = r_held;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_debounce_bank.sv
// Multi-channel button conditioner: N_CH independent channels plus a
// combined press indication for the control FSMs.
module btn_debounce_bank
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_CH            = DEF_N_CH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn_in,
    input  logic [N_CH-1:0] i_repeat_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_held,
    output logic [N_CH-1:0] o_repeat,
    output logic            o_press_any
);

    logic [N_CH-1:0] w_press;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        btn_debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_btn      (i_btn_in[g]),
            .i_repeat_en(i_repeat_en[g]),
            .o_level    (o_level[g]),
            .o_press    (w_press[g]),
            .o_release  (o_release[g]),
            .o_held     (o_held[g]),
            .o_repeat   (o_repeat[g])
        );
    end

    // Press flops are registered per channel, so this OR lands in the same
    // cycle as the individual pulses.
    assign o_press     = w_press;
    assign o_press_any = |w_press;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Randomised and directed stimulus for btn_debounce_bank, compared against
// a window/timestamp reference model every cycle.
module tb_btn_debounce_bank;

    localparam int NCH  = 2;
    localparam int SYN  = 2;
    localparam int DB   = 4;
    localparam int HO   = 20;
    localparam int RP   = 5;
    localparam int MAXE = 16384;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] ren;
    logic [NCH-1:0] o_level, o_press, o_release, o_held, o_repeat;
    logic           o_press_any;

    always #5 clk = ~clk;

    btn_debounce_bank #(
        .N_CH           (NCH),
        .SYNC_STAGES    (SYN),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HO),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_in   (btn),
        .i_repeat_en(ren),
        .o_level    (o_level),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_held     (o_held),
        .o_repeat   (o_repeat),
        .o_press_any(o_press_any)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: level flips when the last DB synchronised samples
    // (all taken after the latest reset) differ from it; held/repeat are
    // derived from the time elapsed since the rising edge.
    bit             bh [NCH][MAXE];
    bit             sp [NCH][MAXE];
    bit             lvl_m [NCH];
    int             t_rise [NCH];
    int             edge_n = 0;
    int             r_last = 0;
    int             k;
    bit             s_m, flip;
    logic [NCH-1:0] m_lvl, m_press, m_rel, m_held, m_rep;
    int             ev_press_m = 0, ev_press_d = 0, ev_rep_m = 0, ev_rep_d = 0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            r_last  = edge_n;
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
            m_held  = '0;
            m_rep   = '0;
            for (int c = 0; c < NCH; c++) lvl_m[c] = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bh[c][edge_n] = btn[c];
                k   = edge_n - SYN;
                s_m = (k > r_last) ? bh[c][k] : 1'b0;
                sp[c][edge_n] = s_m;
                flip = 1'b1;
                for (int j = 0; j < DB; j++)
                    if ((edge_n - j) <= r_last || sp[c][edge_n - j] == lvl_m[c]) flip = 1'b0;
                m_press[c] = flip && !lvl_m[c];
                m_rel[c]   = flip && lvl_m[c];
                if (flip) lvl_m[c] = !lvl_m[c];
                if (m_press[c]) t_rise[c] = edge_n;
                m_lvl[c]  = lvl_m[c];
                m_held[c] = lvl_m[c] && (edge_n - t_rise[c] >= HO);
                m_rep[c]  = m_held[c] && ren[c] && (((edge_n - t_rise[c] - HO) % RP) == 0);
            end
        end
        #1;
        check("level",     o_level,     m_lvl);
        check("press",     o_press,     m_press);
        check("release",   o_release,   m_rel);
        check("held",      o_held,      m_held);
        check("repeat",    o_repeat,    m_rep);
        check("press_any", o_press_any, |m_press);
        check("excl",      o_press & o_release, '0);
        ev_press_m += $countones(m_press);
        ev_press_d += $countones(o_press);
        ev_rep_m   += $countones(m_rep);
        ev_rep_d   += $countones(o_repeat);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks the pulse landing exactly SYN+DB edges after a drive at negedge.
    task automatic expect_press_after_drive(input string tag, input int ch);
        repeat (SYN + DB) @(posedge clk);
        #2;
        check(tag, o_press[ch], 1'b1);
        check({tag, "_any"}, o_press_any, 1'b1);
        @(negedge clk);
    endtask

    int cd [NCH];

    initial begin
        rst = 1'b1;
        btn = '0;
        ren = '0;
        cyc(3);
        rst = 1'b0;

        // clean press
        cyc(10);
        btn[0] = 1'b1;
        expect_press_after_drive("clean_press", 0);
        cyc(6);
        btn[0] = 1'b0;
        cyc(12);

        // bounce, then a press with auto-repeat enabled
        ren[0] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            btn[0] = ~btn[0];
            cyc(2);
        end
        btn[0] = 1'b1;
        expect_press_after_drive("bounce_press", 0);
        cyc(40);
        btn[0] = 1'b0;
        cyc(12);

        // hold with repeat disabled
        ren[0] = 1'b0;
        btn[0] = 1'b1;
        cyc(45);
        btn[0] = 1'b0;
        cyc(12);

        // independence
        btn[0] = 1'b1;
        cyc(2);
        btn[1] = 1'b1;
        cyc(35);
        btn = '0;
        cyc(12);

        // reset mid-hold with input still high
        ren = '1;
        btn[0] = 1'b1;
        cyc(SYN + DB + 12);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        expect_press_after_drive("post_rst_press", 0);
        cyc(35);
        btn[0] = 1'b0;
        cyc(12);

        // random phase
        for (int c = 0; c < NCH; c++) cd[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (cd[c] == 0) begin
                    btn[c] = ~btn[c];
                    cd[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 70))
                                                         : int'($urandom_range(1, 8));
                end else begin
                    cd[c]--;
                end
            end
            if ($urandom_range(0, 49) == 0) ren = NCH'($urandom);
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0;
        btn = '0;
        cyc(20);

        check("press_count",  ev_press_d, ev_press_m);
        check("repeat_count", ev_rep_d,   ev_rep_m);
        check("press_seen",   (ev_press_d > 10), 1'b1);
        check("repeat_seen",  (ev_rep_d > 2),    1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
